// File: rtl/roulette_timer.sv
// Prescaled up-counter with autoreload wrap and interrupt pulse.
// Time base for the Roulette game controller.
module roulette_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tim_prescaler,
  input  logic [WIDTH-1:0] tim_autoreload,
  input  logic             tim_clear,
  input  logic             tim_enable,
  input  logic             tim_mode,
  output logic [WIDTH-1:0] tim_count,
  output logic             timer_int,
  output logic             tim_running
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] psc_cnt;
  logic [WIDTH-1:0] psc_n;
  logic [WIDTH-1:0] count_n;
  logic             int_n;
  logic             done;
  logic             done_n;
  logic             tick;

  assign done        = (state == DONE);
  assign tim_running = (state == RUN);

  always_comb begin
    psc_n   = psc_cnt;
    count_n = tim_count;
    int_n   = 1'b0;
    done_n  = done;
    tick    = 1'b0;
    if (tim_clear) begin
      psc_n   = '0;
      count_n = '0;
      done_n  = 1'b0;
    end else if (tim_enable && !done) begin
      if (psc_cnt >= tim_prescaler) begin
        psc_n = '0;
        tick  = 1'b1;
      end else begin
        psc_n = psc_cnt + WIDTH'(1);
      end
      if (tick) begin
        if (tim_count >= tim_autoreload) begin
          count_n = '0;
          int_n   = 1'b1;
          if (!tim_mode) begin
            done_n = 1'b1;
          end
        end else begin
          count_n = tim_count + WIDTH'(1);
        end
      end
    end else if (!tim_enable) begin
      done_n = 1'b0;
    end
    // Status follows the post-edge done flag
    if (done_n) begin
      state_n = DONE;
    end else if (tim_enable) begin
      state_n = RUN;
    end else begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      psc_cnt   <= '0;
      tim_count <= '0;
      timer_int <= 1'b0;
    end else begin
      state     <= state_n;
      psc_cnt   <= psc_n;
      tim_count <= count_n;
      timer_int <= int_n;
    end
  end

endmodule

// File: tb/tb_roulette_timer.sv
// Directed self-checking bench for roulette_timer.
// Each task drives one scenario and checks outputs inline.
module tb_roulette_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tim_prescaler;
  logic [31:0] tim_autoreload;
  logic        tim_clear;
  logic        tim_enable;
  logic        tim_mode;
  logic [31:0] tim_count;
  logic        timer_int;
  logic        tim_running;

  int vectors = 0;
  int errors  = 0;

  roulette_timer #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .tim_prescaler (tim_prescaler),
    .tim_autoreload(tim_autoreload),
    .tim_clear     (tim_clear),
    .tim_enable    (tim_enable),
    .tim_mode      (tim_mode),
    .tim_count     (tim_count),
    .timer_int     (timer_int),
    .tim_running   (tim_running)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_idle();
    tim_clear  = 1'b1;
    tim_enable = 1'b0;
    tick();
    tim_clear = 1'b0;
    vectors++;
    if (tim_count !== 32'd0 || tim_running !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle count=%0d run=%b want 0/0",
               tim_count, tim_running);
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    tim_prescaler  = 32'd0;
    tim_autoreload = 32'd3;
    tim_clear      = 1'b0;
    tim_enable     = 1'b0;
    tim_mode       = 1'b1;
    tick();
    tick();
    vectors++;
    if (tim_count !== 32'd0 || timer_int !== 1'b0 ||
        tim_running !== 1'b0) begin
      errors++;
      $display("FAIL reset count=%0d int=%b run=%b want 0/0/0",
               tim_count, timer_int, tim_running);
    end
  endtask

  task automatic test_periodic();
    logic [31:0] exp_c;
    rst        = 1'b0;
    tim_enable = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_c = 32'(e % 4);
      vectors++;
      if (tim_count !== exp_c || timer_int !== (e % 4 == 0) ||
          tim_running !== 1'b1) begin
        errors++;
        $display("FAIL periodic e=%0d count=%0d int=%b run=%b want %0d/%b/1",
                 e, tim_count, timer_int, tim_running,
                 exp_c, (e % 4 == 0));
      end
    end
  endtask

  task automatic test_prescaled();
    logic [31:0] exp_c;
    clear_idle();
    tim_prescaler  = 32'd1;
    tim_autoreload = 32'd4;
    tim_mode       = 1'b1;
    tim_enable     = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      exp_c = 32'((e / 2) % 5);
      vectors++;
      if (tim_count !== exp_c || timer_int !== (e % 10 == 0)) begin
        errors++;
        $display("FAIL prescaled e=%0d count=%0d int=%b want %0d/%b",
                 e, tim_count, timer_int, exp_c, (e % 10 == 0));
      end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] exp_c;
    clear_idle();
    tim_prescaler  = 32'd0;
    tim_autoreload = 32'd2;
    tim_mode       = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      tim_enable = 1'b1;
      for (int e = 1; e <= 3; e++) begin
        tick();
        exp_c = 32'(e % 3);
        vectors++;
        if (tim_count !== exp_c || timer_int !== (e == 3) ||
            tim_running !== (e != 3)) begin
          errors++;
          $display("FAIL oneshot p=%0d e=%0d count=%0d int=%b run=%b",
                   pass, e, tim_count, timer_int, tim_running);
        end
      end
      if (pass == 0) begin
        for (int i = 0; i < 20; i++) begin
          tick();
          vectors++;
          if (tim_count !== 32'd0 || timer_int !== 1'b0 ||
              tim_running !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_done i=%0d count=%0d int=%b run=%b",
                     i, tim_count, timer_int, tim_running);
          end
        end
        tim_enable = 1'b0;
        tick();
        vectors++;
        if (tim_count !== 32'd0 || timer_int !== 1'b0) begin
          errors++;
          $display("FAIL oneshot_drop count=%0d int=%b want 0/0",
                   tim_count, timer_int);
        end
      end
    end
  endtask

  task automatic test_pause();
    clear_idle();
    tim_prescaler  = 32'd0;
    tim_autoreload = 32'd9;
    tim_mode       = 1'b1;
    tim_enable     = 1'b1;
    repeat (5) tick();
    tim_enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      vectors++;
      if (tim_count !== 32'd5 || tim_running !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold i=%0d count=%0d run=%b want 5/0",
                 i, tim_count, tim_running);
      end
    end
    tim_enable = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      vectors++;
      if (tim_count !== 32'((5 + e) % 10) || timer_int !== (e == 5)) begin
        errors++;
        $display("FAIL pause_resume e=%0d count=%0d int=%b want %0d/%b",
                 e, tim_count, timer_int, (5 + e) % 10, (e == 5));
      end
    end
  endtask

  task automatic test_clear_on_wrap();
    clear_idle();
    tim_prescaler  = 32'd0;
    tim_autoreload = 32'd3;
    tim_enable     = 1'b1;
    repeat (3) tick();
    tim_clear = 1'b1;
    tick();
    tim_clear = 1'b0;
    vectors++;
    if (tim_count !== 32'd0 || timer_int !== 1'b0 ||
        tim_running !== 1'b1) begin
      errors++;
      $display("FAIL clear_wrap count=%0d int=%b run=%b want 0/0/1",
               tim_count, timer_int, tim_running);
    end
    tick();
    vectors++;
    if (tim_count !== 32'd1 || timer_int !== 1'b0) begin
      errors++;
      $display("FAIL clear_wrap_next count=%0d int=%b want 1/0",
               tim_count, timer_int);
    end
  endtask

  task automatic test_lower_reload();
    clear_idle();
    tim_prescaler  = 32'd0;
    tim_autoreload = 32'd9;
    tim_enable     = 1'b1;
    repeat (5) tick();
    tim_autoreload = 32'd2;
    tick();
    vectors++;
    if (tim_count !== 32'd0 || timer_int !== 1'b1) begin
      errors++;
      $display("FAIL lower_a count=%0d int=%b want 0/1",
               tim_count, timer_int);
    end
    tick();
    vectors++;
    if (tim_count !== 32'd1 || timer_int !== 1'b0) begin
      errors++;
      $display("FAIL lower_a_next count=%0d int=%b want 1/0",
               tim_count, timer_int);
    end
  endtask

  task automatic test_back_to_back();
    clear_idle();
    tim_prescaler  = 32'd0;
    tim_autoreload = 32'd0;
    tim_enable     = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      vectors++;
      if (tim_count !== 32'd0 || timer_int !== 1'b1) begin
        errors++;
        $display("FAIL b2b e=%0d count=%0d int=%b want 0/1",
                 e, tim_count, timer_int);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_idle();
    tim_prescaler  = 32'd1;
    tim_autoreload = 32'd9;
    tim_enable     = 1'b1;
    repeat (7) tick();
    vectors++;
    if (tim_count !== 32'd3) begin
      errors++;
      $display("FAIL rst_mid_pre count=%0d want 3", tim_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (tim_count !== 32'd0 || timer_int !== 1'b0 ||
        tim_running !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid count=%0d int=%b run=%b want 0/0/0",
               tim_count, timer_int, tim_running);
    end
    for (int e = 1; e <= 4; e++) begin
      tick();
      vectors++;
      if (tim_count !== 32'(e / 2) || tim_running !== 1'b1) begin
        errors++;
        $display("FAIL rst_restart e=%0d count=%0d run=%b want %0d/1",
                 e, tim_count, tim_running, e / 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_prescaled();
    test_oneshot();
    test_pause();
    test_clear_on_wrap();
    test_lower_reload();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/roulette_timer.md
# roulette_timer

Programmable prescaled up-counter that answers the Roulette game controller's timer-control interface. The controller drives prescaler, autoreload, clear, enable and mode. This block returns the live count and a one-cycle interrupt pulse on every autoreload wrap. It is instanced next to the game controller and is its only time base for spin pacing and finish timing.

## Interface
- WIDTH, 32, width of the prescaler, autoreload and count datapaths.

- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tim_prescaler  in  WIDTH  prescale value P; the count advances once every P+1 enabled clocks.
- tim_autoreload  in  WIDTH  wrap value A; the count runs 0..A, then wraps to 0.
- tim_clear  in  1  synchronous clear of the prescaler and count; level-sensitive.
- tim_enable  in  1  1 = count, 0 = pause (state is held).
- tim_mode  in  1  1 = periodic, 0 = one-shot.
- tim_count  out  WIDTH  current count value (registered).
- timer_int  out  1  one-cycle pulse on each wrap (registered).
- tim_running  out  1  1 while counting is active (enable=1 and not in one-shot done).

## Operation
- Internal state:
  - psc_cnt (WIDTH bits).
  - tim_count.
  - done flag.
  - Status is one of three states: IDLE (enable=0), RUN, DONE.
- Priority per edge, highest first: rst, then tim_clear, then counting.
- rst: psc_cnt=0, tim_count=0, timer_int=0, done=0, tim_running=0.
- tim_clear=1 (regardless of enable):
  - psc_cnt=0, tim_count=0, done=0, timer_int=0.
  - The clear overrides any wrap due in the same cycle; no interrupt is produced.
- Step condition: tim_enable=1 and done=0. When it holds:
  - If psc_cnt >= P: psc_cnt←0 and a tick occurs.
  - Otherwise: psc_cnt←psc_cnt+1.
- On a tick:
  - If tim_count >= A: tim_count←0 and timer_int←1. If tim_mode=0, also set done←1.
  - Otherwise: tim_count←tim_count+1.
- timer_int is 0 on every edge that does not produce a wrap, so the pulse is exactly one cycle wide.
- DONE (one-shot complete):
  - tim_count holds 0, psc_cnt holds 0, and no further ticks or interrupts occur.
  - Exit by tim_clear=1, or by tim_enable=0 (done←0 on that edge). The next enabled cycle starts a fresh period.
- tim_enable=0 with done=0: psc_cnt and tim_count hold. Re-enabling resumes from the held values.
- P and A are sampled live every cycle; there is no shadow register.
  - The >= compares make a reduction below the current psc_cnt or tim_count take effect on the next step: an immediate tick, or an immediate wrap.
  - Increasing A or P mid-period extends the current period.
- A=0: every tick wraps, and timer_int pulses once per P+1 enabled clocks. P=0 and A=0 gives timer_int=1 on every enabled cycle.
- tim_mode changes take effect at the next wrap.
- Arithmetic:
  - Counters are unsigned WIDTH-bit.
  - Overflow is impossible, because both counters are reset before exceeding P or A; an all-ones value works with >= compare.
- tim_running = tim_enable & ~done, registered. It is 0 in reset and 0 in the cycle after a clear with enable=0.

## Timing
- Period in periodic mode: (P+1)*(A+1) enabled clocks between timer_int pulses.
- The first wrap occurs (P+1)*(A+1) enabled edges after a clear or reset.
- timer_int is asserted in the same cycle that tim_count reads 0 after the wrap. Both are registered outputs of the same edge.
- Latency:
  - tim_clear is seen at tim_count on the next edge.
  - tim_enable takes effect on the edge where it is sampled high; the first step happens on that edge.
- Reset mid-period discards all progress. Outputs read 0 after the reset edge.

## Test plan
- Reset, then P=0, A=3, mode=1, enable=1 from edge 1:
  - tim_count reads 1, 2, 3, then 0 with timer_int=1 at edge 4.
  - Pulses repeat at edges 8 and 12.
  - Each pulse is 1 cycle wide.
- P=1, A=4, mode=1: timer_int pulses exactly every 10 cycles, and tim_count changes every 2 cycles.
- One-shot, P=0, A=2, mode=0:
  - A single pulse occurs at edge 3; then tim_count=0, tim_running=0, and no further pulse for 20 cycles.
  - Drop enable for 1 cycle, then re-raise it: the next pulse comes 3 enabled edges later.
- Pause: P=0, A=9, disable at tim_count=5 for 7 cycles: tim_count holds 5, then resumes at 6, and the wrap arrives 5 enabled edges after resume.
- Boundaries:
  - tim_clear asserted on the exact cycle a wrap is due: tim_count=0, timer_int=0.
  - A lowered from 9 to 2 while tim_count=5: the wrap and pulse occur on the next tick.
- rst asserted mid-count (tim_count=3, psc_cnt=1, enable still 1): after the reset edge all outputs are 0, and counting restarts from 0 after rst deasserts.
